alu_result_stage: RTL and testbench

Registered output stage directly downstream of the 16-bit 3:1 ALU result mux. It captures the selected 16-bit result together with its 2-bit source tag. At capture it computes the zero, negative and illegal-select flags. It then presents the entry to the writeback/forwarding logic through a valid/ready handshake, using a 2-entry skid buffer so the ALU never loses a result when writeback stalls.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_entry_reg.sv | 50 +++++
 rtl/alu_result_stage.sv | 139 +++++++++++++
 tb/tb_alu_result_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU result types, select codes and entry-flag helper.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    SEL_B   = 2'd0,
    SEL_C   = 2'd1,
    SEL_D   = 2'd2,
    SEL_BAD = 2'd3
  } alu_sel_e;

  typedef struct packed {
    logic [ALU_W-1:0] data;
    logic [1:0]       sel;
    logic             zero;
    logic             neg;
    logic             err;
  } alu_entry_t;

  function automatic alu_entry_t alu_mk_entry(input logic [ALU_W-1:0] data,
                                              input logic [1:0]       sel);
    alu_entry_t e;
    e.data = data;
    e.sel  = sel;
    e.zero = (data == '0);
    e.neg  = data[ALU_W-1];
    e.err  = (sel == SEL_BAD);
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_entry_reg
//  Purpose  : One result entry (data, tag, flags) with its own valid bit.
//  Revision : 1.0  initial release
// ============================================================================
module alu_entry_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clkpos,
  input  logic             rst,
  input  logic             load_valid,
  input  logic             valid_d,
  input  logic             load_data,
  input  logic [WIDTH-1:0] d_data,
  input  logic [1:0]       d_sel,
  input  logic             d_zero,
  input  logic             d_neg,
  input  logic             d_err,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data,
  output logic [1:0]       q_sel,
  output logic             q_zero,
  output logic             q_neg,
  output logic             q_err
);

  always_ff @(posedge clkpos or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_sel   <= 2'd0;
      q_zero  <= 1'b0;
      q_neg   <= 1'b0;
      q_err   <= 1'b0;
    end else begin
      if (load_valid) q_valid <= valid_d;
      // Payload is only rewritten on a load so it holds after the entry drains.
      if (load_data) begin
        q_data <= d_data;
        q_sel  <= d_sel;
        q_zero <= d_zero;
        q_neg  <= d_neg;
        q_err  <= d_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_stage
//  Purpose  : Registered ALU result stage with a 2-entry skid buffer.
//  Revision : 1.0  initial release
// ============================================================================
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clkpos,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_err,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  occ_e       r_state;
  occ_e       w_next;
  logic       r_in_ready;
  logic       w_push;
  logic       w_pop;
  logic       w_main_ld;
  logic       w_skid_ld;
  logic       w_main_from_skid;
  logic       w_skid_valid;
  alu_entry_t w_in_entry;
  alu_entry_t w_skid_q;
  alu_entry_t w_main_d;

  assign w_push     = in_valid & r_in_ready;
  assign w_pop      = out_valid & out_ready;
  assign w_in_entry = alu_mk_entry(in_data, in_sel);
  assign w_main_d   = w_main_from_skid ? w_skid_q : w_in_entry;

  always_comb begin
    w_next           = r_state;
    w_main_ld        = 1'b0;
    w_skid_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_next    = ST_ONE;
          w_main_ld = 1'b1;
        end
      end
      ST_ONE: begin
        case ({w_push, w_pop})
          2'b11:   w_main_ld = 1'b1;
          2'b10: begin
            w_next    = ST_FULL;
            w_skid_ld = 1'b1;
          end
          2'b01:   w_next = ST_EMPTY;
          default: w_next = ST_ONE;
        endcase
      end
      ST_FULL: begin
        // Skid is always older than anything upstream, so it refills main first.
        if (w_pop && w_skid_valid) begin
          w_next           = ST_ONE;
          w_main_ld        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clkpos or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != ST_FULL);
    end
  end

  assign in_ready  = r_in_ready;
  assign occupancy = r_state;

  alu_entry_reg #(.WIDTH(WIDTH)) u_main (
    .clkpos     (clkpos),
    .rst        (rst),
    .load_valid (1'b1),
    .valid_d    (w_next != ST_EMPTY),
    .load_data  (w_main_ld),
    .d_data     (w_main_d.data),
    .d_sel      (w_main_d.sel),
    .d_zero     (w_main_d.zero),
    .d_neg      (w_main_d.neg),
    .d_err      (w_main_d.err),
    .q_valid    (out_valid),
    .q_data     (out_data),
    .q_sel      (out_sel),
    .q_zero     (out_zero),
    .q_neg      (out_neg),
    .q_err      (out_err)
  );

  alu_entry_reg #(.WIDTH(WIDTH)) u_skid (
    .clkpos     (clkpos),
    .rst        (rst),
    .load_valid (1'b1),
    .valid_d    (w_next == ST_FULL),
    .load_data  (w_skid_ld),
    .d_data     (w_in_entry.data),
    .d_sel      (w_in_entry.sel),
    .d_zero     (w_in_entry.zero),
    .d_neg      (w_in_entry.neg),
    .d_err      (w_in_entry.err),
    .q_valid    (w_skid_valid),
    .q_data     (w_skid_q.data),
    .q_sel      (w_skid_q.sel),
    .q_zero     (w_skid_q.zero),
    .q_neg      (w_skid_q.neg),
    .q_err      (w_skid_q.err)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_stage
//  Purpose  : Randomised bench for alu_result_stage against a 2-deep queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_stage;

  logic        clkpos = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic        out_err;
  logic [1:0]  occupancy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  s;
  } ent_t;
  ent_t q[$];

  always #5 clkpos = ~clkpos;

  alu_result_stage #(.WIDTH(16)) dut (
    .clkpos    (clkpos),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_err   (out_err),
    .occupancy (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("in_ready",  32'(in_ready),  32'(q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("occupancy", 32'(occupancy), 32'(q.size()));
    if (q.size() > 0) begin
      check("out_data", 32'(out_data), 32'(q[0].d));
      check("out_sel",  32'(out_sel),  32'(q[0].s));
      check("out_zero", 32'(out_zero), 32'(q[0].d == 16'h0000));
      check("out_neg",  32'(out_neg),  32'(q[0].d >= 16'h8000));
      check("out_err",  32'(out_err),  32'(q[0].s == 2'd3));
    end
  endtask

  // Called just after a falling edge: check, drive, clock, update the model.
  task automatic step(input logic iv, input logic [15:0] d, input logic [1:0] s,
                      input logic ordy);
    logic push, pop;
    compare_outputs();
    in_valid  = iv;
    in_data   = d;
    in_sel    = s;
    out_ready = ordy;
    push = iv && (q.size() < 2);
    pop  = ordy && (q.size() > 0);
    @(posedge clkpos);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back('{d: d, s: s});
    @(negedge clkpos);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_out_flags"}, 32'({out_sel, out_zero, out_neg, out_err}), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_sel    = 2'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clkpos);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clkpos);

    // Single transfer of a zero result, then drain.
    step(1'b1, 16'h0000, 2'd2, 1'b1);
    step(1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b0, 16'h0000, 2'd0, 1'b1);

    // Back-pressure fill: third word must be refused.
    step(1'b1, 16'h8001, 2'd0, 1'b0);
    step(1'b1, 16'h1234, 2'd1, 1'b0);
    step(1'b1, 16'h5555, 2'd2, 1'b0);
    step(1'b1, 16'h5555, 2'd2, 1'b0);

    // Drain order from FULL.
    step(1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b0, 16'h0000, 2'd0, 1'b0);

    // Streaming through ONE with simultaneous push/pop.
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 2'(i % 3), 1'b1);
    step(1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b0, 16'h0000, 2'd0, 1'b1);

    // Illegal select still captured.
    step(1'b1, 16'hFFFF, 2'd3, 1'b0);
    step(1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b0, 16'h0000, 2'd0, 1'b1);

    // Asynchronous reset while FULL.
    step(1'b1, 16'hA5A5, 2'd1, 1'b0);
    step(1'b1, 16'h0F0F, 2'd2, 1'b0);
    compare_outputs();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    q.delete();
    @(negedge clkpos);
    rst = 1'b0;
    @(negedge clkpos);
    step(1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b0, 16'h0000, 2'd0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 7))
        0:       d = 16'h0000;
        1:       d = 16'h8000 | 16'($urandom);
        default: d = 16'($urandom);
      endcase
      step(1'($urandom_range(0, 3) != 0), d, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 9) < 6));
    end
    compare_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
